// File: rtl/fma16_pkg.sv
// fma16_pkg: shared types and constants for the fp16 adder.
package fma16_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ALIGN,
    ADD,
    NORM,
    ROUND,
    DONE
  } state_t;

  localparam logic [4:0]  BIAS    = 5'd15;
  localparam logic [4:0]  EXP_MAX = 5'd31;
  localparam logic [15:0] QNAN    = 16'h7E00;

  // bit positions inside the 4-bit flags word {NV, OF, UF, NX}
  localparam int NV = 3;
  localparam int OF = 2;
  localparam int UF = 1;
  localparam int NX = 0;

endpackage

// File: rtl/fma16_fadd_if.sv
// fma16_fadd_if: operand/result handshake bundle for fma16_fadd.
interface fma16_fadd_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] x;
  logic [15:0] z;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic [3:0]  flags;

  modport master (
    output in_valid, x, z, out_ready,
    input  in_ready, out_valid, result, flags
  );

  modport slave (
    input  in_valid, x, z, out_ready,
    output in_ready, out_valid, result, flags
  );
endinterface

// File: rtl/fma16_lzc.sv
// fma16_lzc: combinational leading-zero count of a 15-bit vector.
// An all-zero input reports 15.
module fma16_lzc (
  input  logic [14:0] vec,
  output logic [3:0]  count
);

  // scan upward so the highest set bit is the last one to assign
  always_comb begin
    count = 4'd15;
    for (int i = 0; i < 15; i++) begin
      if (vec[i]) count = 4'(14 - i);
    end
  end

endmodule

// File: rtl/fma16_fadd.sv
// fma16_fadd: multi-cycle IEEE binary16 adder (result = x + z), the
// accumulate half of an FMA. One operation in flight; subnormal inputs are
// flushed to signed zero and tiny results flush to signed zero with UF/NX.
// Build option FMA16_ROUND_RNE_EN: round-to-nearest-even, overflow to inf.
// Without it: truncation, overflow to max finite. Flags/latency identical.
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// ALIGN | decode, special values, shift smaller operand right
// ADD   | add or subtract aligned magnitudes
// NORM  | renormalise to a leading one at bit 13
// ROUND | round, detect overflow/underflow, load result/flags
// DONE  | out_valid high, hold until out_ready
module fma16_fadd
  import fma16_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  fma16_fadd_if.slave bus
);

  state_t state, state_next;

  logic [15:0] x_r, z_r;

  logic        sign_a, sign_b;
  logic [13:0] mag_a, mag_b;
  logic [4:0]  exp_a;
  logic        special;
  logic [15:0] spec_res;
  logic [3:0]  spec_flags;

  logic        sign_s;
  logic [14:0] sum;

  logic        sign_n, zero_n;
  logic [13:0] mant_n;
  logic signed [6:0] exp_n;

  logic [15:0] result_r;
  logic [3:0]  flags_r;

  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // next state and handshake outputs
  always_comb begin
    state_next    = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_next = ALIGN;
      end
      ALIGN: state_next = ADD;
      ADD:   state_next = NORM;
      NORM:  state_next = ROUND;
      ROUND: state_next = DONE;
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.result = result_r;
  assign bus.flags  = flags_r;

  logic [4:0]  ex, ez, big_exp, diff;
  logic [9:0]  fx, fz;
  logic        x_big, x_nan, z_nan, x_inf, z_inf;
  logic [13:0] ext_x, ext_z, big_ext, small_ext, small_shr, lost_mask, aligned;
  logic        al_special;
  logic [15:0] al_spec_res;
  logic [3:0]  al_spec_flags;

  // decode operands, catch NaN/inf, align the smaller-exponent operand
  always_comb begin
    ex        = x_r[14:10];
    ez        = z_r[14:10];
    fx        = x_r[9:0];
    fz        = z_r[9:0];
    x_nan     = (ex == EXP_MAX) && (fx != '0);
    z_nan     = (ez == EXP_MAX) && (fz != '0);
    x_inf     = (ex == EXP_MAX) && (fx == '0);
    z_inf     = (ez == EXP_MAX) && (fz == '0);
    // exponent 0 means zero or subnormal: both become a zero significand
    ext_x     = (ex == '0) ? '0 : {1'b1, fx, 3'b000};
    ext_z     = (ez == '0) ? '0 : {1'b1, fz, 3'b000};
    x_big     = (ex >= ez);
    big_exp   = x_big ? ex : ez;
    diff      = x_big ? (ex - ez) : (ez - ex);
    big_ext   = x_big ? ext_x : ext_z;
    small_ext = x_big ? ext_z : ext_x;
    small_shr = small_ext >> diff;
    lost_mask = ~(14'h3FFF << diff);
    if (diff >= 5'd14) aligned = {13'b0, |small_ext};
    else               aligned = {small_shr[13:1], small_shr[0] | (|(small_ext & lost_mask))};

    al_special    = 1'b1;
    al_spec_res   = QNAN;
    al_spec_flags = '0;
    if (x_nan || z_nan) begin
      al_spec_res = QNAN;
    end else if (x_inf && z_inf && (x_r[15] != z_r[15])) begin
      al_spec_flags[NV] = 1'b1;
    end else if (x_inf) begin
      al_spec_res = x_r;
    end else if (z_inf) begin
      al_spec_res = z_r;
    end else begin
      al_special = 1'b0;
    end
  end

  logic [14:0] add_sum;
  logic        add_sign;

  // signed-magnitude add; the larger magnitude decides the sign
  always_comb begin
    if (sign_a == sign_b) begin
      add_sum  = {1'b0, mag_a} + {1'b0, mag_b};
      add_sign = sign_a;
    end else if (mag_a >= mag_b) begin
      add_sum  = {1'b0, mag_a - mag_b};
      add_sign = sign_a;
    end else begin
      add_sum  = {1'b0, mag_b - mag_a};
      add_sign = sign_b;
    end
    // exact cancellation is +0; only two negative zeros stay negative
    if (add_sum == '0) add_sign = sign_a & sign_b;
  end

  logic [3:0]  lz, shamt;
  logic [13:0] norm_mant;
  logic signed [6:0] norm_exp;

  fma16_lzc u_lzc (
    .vec   (sum),
    .count (lz)
  );

  // put the leading one at bit 13; bit 14 is the adder carry
  always_comb begin
    shamt = lz - 4'd1;
    if (sum[14]) begin
      norm_mant = {sum[14:2], sum[1] | sum[0]};
      norm_exp  = $signed({2'b00, exp_a}) + 7'sd1;
    end else begin
      norm_mant = sum[13:0] << shamt;
      norm_exp  = $signed({2'b00, exp_a}) - $signed({3'b000, shamt});
    end
  end

  logic        round_up, inexact;
  logic [11:0] mant_r;
  logic signed [6:0] exp_r;
  logic [9:0]  frac_r;
  logic [15:0] rnd_res;
  logic [3:0]  rnd_flags;

  // round the normalised value and choose the final result/flags
  always_comb begin
    inexact = |mant_n[2:0];
`ifdef FMA16_ROUND_RNE_EN
    round_up = mant_n[2] & (mant_n[3] | mant_n[1] | mant_n[0]);
`else
    round_up = 1'b0;
`endif
    mant_r    = {1'b0, mant_n[13:3]} + {11'b0, round_up};
    exp_r     = exp_n + (mant_r[11] ? 7'sd1 : 7'sd0);
    frac_r    = mant_r[11] ? mant_r[10:1] : mant_r[9:0];
    rnd_res   = {sign_n, exp_r[4:0], frac_r};
    rnd_flags = {3'b000, inexact};
    if (special) begin
      rnd_res   = spec_res;
      rnd_flags = spec_flags;
    end else if (zero_n) begin
      rnd_res   = {sign_n, 15'b0};
      rnd_flags = '0;
    end else if (exp_n < 7'sd1) begin
      rnd_res       = {sign_n, 15'b0};
      rnd_flags     = '0;
      rnd_flags[UF] = 1'b1;
      rnd_flags[NX] = 1'b1;
    end else if (exp_r >= $signed({2'b00, EXP_MAX})) begin
      rnd_flags     = '0;
      rnd_flags[OF] = 1'b1;
      rnd_flags[NX] = 1'b1;
`ifdef FMA16_ROUND_RNE_EN
      rnd_res = {sign_n, 5'h1F, 10'h000};
`else
      rnd_res = {sign_n, 5'h1E, 10'h3FF};
`endif
    end
  end

  // stage registers: each state loads the intermediates the next one needs
  always_ff @(posedge clk) begin
    if (reset) begin
      x_r        <= '0;
      z_r        <= '0;
      sign_a     <= 1'b0;
      sign_b     <= 1'b0;
      mag_a      <= '0;
      mag_b      <= '0;
      exp_a      <= '0;
      special    <= 1'b0;
      spec_res   <= '0;
      spec_flags <= '0;
      sign_s     <= 1'b0;
      sum        <= '0;
      sign_n     <= 1'b0;
      zero_n     <= 1'b0;
      mant_n     <= '0;
      exp_n      <= '0;
      result_r   <= '0;
      flags_r    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            x_r <= bus.x;
            z_r <= bus.z;
          end
        end
        ALIGN: begin
          sign_a     <= x_big ? x_r[15] : z_r[15];
          sign_b     <= x_big ? z_r[15] : x_r[15];
          mag_a      <= big_ext;
          mag_b      <= aligned;
          exp_a      <= big_exp;
          special    <= al_special;
          spec_res   <= al_spec_res;
          spec_flags <= al_spec_flags;
        end
        ADD: begin
          sum    <= add_sum;
          sign_s <= add_sign;
        end
        NORM: begin
          mant_n <= norm_mant;
          exp_n  <= norm_exp;
          sign_n <= sign_s;
          zero_n <= (sum == '0);
        end
        ROUND: begin
          result_r <= rnd_res;
          flags_r  <= rnd_flags;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fma16_fadd.sv
// tb_fma16_fadd: directed bench for fma16_fadd. A value-level model (exact
// integer sum, then rounding) predicts every result; a compare process checks
// the DUT against it each cycle out_valid is high, and directed vectors pin
// literal results.
module tb_fma16_fadd;

  logic clk;
  logic reset;

  fma16_fadd_if bus ();

  fma16_fadd dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] r;
    logic [3:0]  f;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  // exact sum in units of 2^-24, then normalise and round by value
  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b);
    exp_t   o;
    int     ea, eb, p, e, sh;
    longint va, vb, s, mag, mant, rem;
    logic   neg, nx;
    ea  = int'(a[14:10]);
    eb  = int'(b[14:10]);
    o.r = 16'h7E00;
    o.f = 4'b0000;
    if ((ea == 31 && a[9:0] != 0) || (eb == 31 && b[9:0] != 0)) return o;
    if (ea == 31 && eb == 31 && a[15] != b[15]) begin
      o.f = 4'b1000;
      return o;
    end
    if (ea == 31) begin o.r = a; return o; end
    if (eb == 31) begin o.r = b; return o; end
    va = (ea == 0) ? 64'sd0 : (longint'({1'b1, a[9:0]}) << (ea - 1));
    vb = (eb == 0) ? 64'sd0 : (longint'({1'b1, b[9:0]}) << (eb - 1));
    if (a[15]) va = -va;
    if (b[15]) vb = -vb;
    s = va + vb;
    if (s == 0) begin
      o.r = (a[15] && b[15]) ? 16'h8000 : 16'h0000;
      return o;
    end
    neg = (s < 0);
    mag = neg ? -s : s;
    p = 0;
    for (int i = 0; i < 48; i++) if (mag[i]) p = i;
    e = p - 9;
    if (e < 1) begin
      o.r = {neg, 15'b0};
      o.f = 4'b0011;
      return o;
    end
    sh   = p - 10;
    mant = mag >> sh;
    rem  = mag - (mant << sh);
    nx   = (rem != 0);
`ifdef FMA16_ROUND_RNE_EN
    if (sh > 0) begin
      longint half;
      half = longint'(1) << (sh - 1);
      if (rem > half || (rem == half && mant[0])) mant++;
    end
    if (mant == 2048) begin
      mant = 1024;
      e++;
    end
`endif
    if (e >= 31) begin
      o.f = 4'b0101;
`ifdef FMA16_ROUND_RNE_EN
      o.r = {neg, 15'h7C00};
`else
      o.r = {neg, 15'h7BFF};
`endif
    end else begin
      o.r = {neg, e[4:0], mant[9:0]};
      o.f = {3'b000, nx};
    end
    return o;
  endfunction

  // every cycle with out_valid: result/flags must equal the oldest prediction
  initial begin : compare
    forever begin
      @(negedge clk);
      if (!reset && bus.out_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_out_valid", {31'b0, bus.out_valid}, 32'd0);
        end else begin
          check("model_result", bus.result, exp_q[0].r);
          check("model_flags", bus.flags, exp_q[0].f);
          if (bus.out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic send(input logic [15:0] a, input logic [15:0] b);
    int   tries;
    exp_t e;
    tries = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.x        = a;
    bus.z        = b;
    while (!bus.in_ready && tries < 50) begin
      @(negedge clk);
      tries++;
    end
    if (!bus.in_ready) begin
      check("send_ready", {31'b0, bus.in_ready}, 32'd1);
      bus.in_valid = 1'b0;
      return;
    end
    e = model(a, b);
    exp_q.push_back(e);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  // lat = index of the first cycle after the accept edge with out_valid high
  task automatic wait_out(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.out_valid && lat < 20);
  endtask

  task automatic do_op(input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] er, input logic [3:0] ef,
                       input string name, input bit lit);
    int lat;
    send(a, b);
    wait_out(lat);
    check({name, "_latency"}, lat, 32'd5);
    if (lit) begin
      check({name, "_result"}, bus.result, er);
      check({name, "_flags"}, bus.flags, ef);
    end
    @(negedge clk);
    check({name, "_back_idle"}, {31'b0, bus.in_ready}, 32'd1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int lat;
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.x         = '0;
    bus.z         = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
    check("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("rst_result", bus.result, 32'h0000);
    check("rst_flags", bus.flags, 32'h0);

    do_op(16'h3C00, 16'h3C00, 16'h4000, 4'b0000, "one_plus_one", 1'b1);
    do_op(16'h3C00, 16'hBC00, 16'h0000, 4'b0000, "cancel", 1'b1);
    do_op(16'h3C00, 16'h0C00, 16'h3C00, 4'b0001, "tiny_addend", 1'b1);
`ifdef FMA16_ROUND_RNE_EN
    do_op(16'h7BFF, 16'h7BFF, 16'h7C00, 4'b0101, "overflow", 1'b1);
    do_op(16'h3C01, 16'h1000, 16'h3C02, 4'b0001, "tie_odd", 1'b1);
`else
    do_op(16'h7BFF, 16'h7BFF, 16'h7BFF, 4'b0101, "overflow", 1'b1);
    do_op(16'h3C01, 16'h1000, 16'h3C01, 4'b0001, "tie_odd", 1'b1);
`endif
    do_op(16'h7C00, 16'hFC00, 16'h7E00, 4'b1000, "inf_minus_inf", 1'b1);
    do_op(16'h7E00, 16'h3C00, 16'h7E00, 4'b0000, "nan_in", 1'b1);
    do_op(16'h4000, 16'h3C00, 16'h4200, 4'b0000, "two_plus_one", 1'b1);
    do_op(16'h3C00, 16'hC000, 16'hBC00, 4'b0000, "neg_result", 1'b1);
    do_op(16'h8000, 16'h8000, 16'h8000, 4'b0000, "neg_zeros", 1'b1);
    do_op(16'h0000, 16'h8000, 16'h0000, 4'b0000, "mixed_zeros", 1'b1);
    do_op(16'h7C00, 16'h3C00, 16'h7C00, 4'b0000, "inf_plus_fin", 1'b1);
    do_op(16'hFC00, 16'hFC00, 16'hFC00, 4'b0000, "ninf_ninf", 1'b1);
    do_op(16'h0400, 16'h8401, 16'h8000, 4'b0011, "underflow", 1'b1);
    do_op(16'h0001, 16'h3C00, 16'h3C00, 4'b0000, "subnormal_ftz", 1'b1);
    do_op(16'h3C00, 16'h9000, 16'h3BFF, 4'b0000, "left_norm", 1'b1);
    do_op(16'h5000, 16'h0400, 16'h5000, 4'b0001, "sticky_only", 1'b1);
    do_op(16'h3C00, 16'h1000, 16'h3C00, 4'b0001, "tie_even", 1'b1);
    do_op(16'hC000, 16'hC000, 16'hC400, 4'b0000, "neg_carry", 1'b1);

    // backpressure: hold DONE for three cycles with in_valid pulsing
    bus.out_ready = 1'b0;
    send(16'h4000, 16'h4000);
    wait_out(lat);
    check("bp_latency", lat, 32'd5);
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.x        = 16'h1234;
      bus.z        = 16'h5678;
      @(negedge clk);
      check("bp_hold_result", bus.result, 32'h4400);
      check("bp_hold_flags", bus.flags, 32'h0);
      check("bp_in_ready", {31'b0, bus.in_ready}, 32'd0);
      check("bp_out_valid", {31'b0, bus.out_valid}, 32'd1);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_ready", {31'b0, bus.in_ready}, 32'd1);
    check("bp_release_valid", {31'b0, bus.out_valid}, 32'd0);

    // reset for one edge while the operation sits in ADD
    send(16'h3C00, 16'h3C00);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("midrst_in_ready", {31'b0, bus.in_ready}, 32'd1);
    check("midrst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("midrst_result", bus.result, 32'h0000);
    check("midrst_flags", bus.flags, 32'h0);
    do_op(16'h4000, 16'h4000, 16'h4400, 4'b0000, "after_reset", 1'b1);

    // spread of finite operands, close and far exponents, checked by the model
    for (int i = 0; i < 24; i++) begin
      logic [15:0] a, b;
      int ea, eb;
      ea = int'($urandom_range(1, 30));
      if (i % 3 == 0) eb = int'($urandom_range(1, 30));
      else            eb = ea - 2 + int'($urandom_range(0, 4));
      if (eb < 1)  eb = 1;
      if (eb > 30) eb = 30;
      a = {1'($urandom_range(0, 1)), 5'(ea), 10'($urandom)};
      b = {1'($urandom_range(0, 1)), 5'(eb), 10'($urandom)};
      do_op(a, b, 16'h0000, 4'b0000, "sweep", 1'b0);
    end

    repeat (2) @(negedge clk);
    check("queue_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fma16_fadd.md
FMA16_FADD -- requirements
Module: fma16_fadd

Interface
REQ-001 Block SHALL have no parameters; all widths are fixed for IEEE 754 binary16.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  operand pair x/z valid.
REQ-005 in_ready  output  1  block can accept operands.
REQ-006 x  input  16  fp16 addend, normally the product from the upstream multiplier.
REQ-007 z  input  16  fp16 addend.
REQ-008 out_valid  output  1  result/flags valid.
REQ-009 out_ready  input  1  downstream accepts result.
REQ-010 result  output  16  fp16 sum x+z.
REQ-011 flags  output  4  {NV, OF, UF, NX}: bit3 invalid, bit2 overflow, bit1 underflow, bit0 inexact.

Function
REQ-012 FSM states SHALL be IDLE, ALIGN, ADD, NORM, ROUND, DONE.
REQ-013 in_ready SHALL be 1 only in IDLE; a handshake is in_valid & in_ready; x and z SHALL be registered on it, moving IDLE->ALIGN.
REQ-014 ALIGN->ADD->NORM->ROUND->DONE SHALL advance unconditionally, one state per cycle; out_valid SHALL rise exactly 5 cycles after the accepting edge.
REQ-015 In DONE, out_valid=1; result/flags SHALL hold stable until out_valid & out_ready, then go to IDLE. The next accept is no earlier than the following cycle.
REQ-016 ALIGN: significands SHALL be {1, frac} in 11 bits, extended by guard/round/sticky to 14 bits. The smaller-exponent operand SHALL be shifted right by the exponent difference. Bits shifted out SHALL OR into sticky. A difference >= 14 SHALL leave only sticky.
REQ-017 ADD: equal signs SHALL add (15-bit with carry); unequal signs SHALL subtract the smaller magnitude from the larger. The result sign SHALL be the larger-magnitude sign.
REQ-018 NORM: a carry SHALL shift right 1 (sticky preserved) and increment the exponent. Otherwise shift left by the leading-zero count and decrement the exponent.
REQ-019 Exact cancellation SHALL give +0; (-0)+(-0) SHALL give -0.
REQ-020 Input exponent 0 (zero/subnormal) SHALL be treated as signed zero (flush-to-zero).
REQ-021 A normalized exponent < 1 SHALL output signed zero with UF=1 and NX=1.
REQ-022 Exponent >= 31 after rounding SHALL set OF=1 and NX=1; the overflowed value is governed by REQ-027.
REQ-023 Any NaN input, or inf + (-inf), SHALL give 0x7E00. The second case SHALL set NV=1. inf + finite SHALL give that inf with flags 0.
REQ-024 NX SHALL be 1 whenever any guard, round or sticky bit is nonzero.
REQ-025 Flags SHALL describe the current operation only; nothing accumulates.

Reset
REQ-026 While reset=1 at a clock edge: state SHALL become IDLE, out_valid=0, result=0x0000, flags=4'b0000 at the next cycle. in_ready=1 from the first cycle after reset. An in-flight operation is discarded mid-operation with no output.

Configuration
REQ-027 FMA16_ROUND_RNE_EN affects the ROUND state only:
- Defined: round-to-nearest-even; overflow gives signed inf (0x7C00/0xFC00).
- Undefined: truncation (round toward zero); overflow gives max finite (0x7BFF/0xFBFF).
- Flags and latency are identical in both builds.

Structure
REQ-028 Package fma16_pkg SHALL hold the state enum, BIAS=15, EXP_MAX=31, QNAN=16'h7E00, and flag bit indices NV/OF/UF/NX.
REQ-029 Sub-module fma16_lzc SHALL give a combinational 4-bit leading-zero count of a 15-bit vector for NORM.
REQ-030 Intermediate sign, exponent and significand SHALL be registered between states (no combinational path from x/z to result).

Verification
REQ-031 x=0x3C00, z=0x3C00 -> result=0x4000, flags=0, out_valid exactly 5 cycles after accept.
REQ-032 x=0x3C00, z=0xBC00 -> 0x0000, flags=0. x=0x3C00, z=0x0C00 -> 0x3C00, NX=1 (both builds).
REQ-033 x=0x7BFF, z=0x7BFF -> with macro 0x7C00, flags=0101; without macro 0x7BFF, flags=0101.
REQ-034 x=0x7C00, z=0xFC00 -> 0x7E00, flags=1000. x=0x7E00, z=0x3C00 -> 0x7E00, flags=0000.
REQ-035 Backpressure: out_ready=0 for 3 cycles in DONE -> result/flags stable, in_ready=0, in_valid ignored. Then out_ready=1 -> IDLE next cycle.
REQ-036 Assert reset for one edge while in ADD -> next cycle IDLE, out_valid=0, result=0x0000, flags=0. A new 0x4000+0x4000 then yields 0x4400.
